// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT upstream adder results with saturation,
// then holds total, average and overflow until the consumer takes them.
module sum_accum #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [4:0]       avg_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SH = $clog2(COUNT);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t state, state_nx;

  logic [SH-1:0]    cnt;
  logic [ACC_W-1:0] acc;
  logic             sticky;

  logic             accept;
  logic             last;
  logic             done;
  logic [ACC_W:0]   sum_ext;
  logic             ovf_add;
  logic             ovf_nx;
  logic [ACC_W-1:0] acc_nx;
  logic [ACC_W-1:0] shifted;
  logic [4:0]       avg_nx;

  assign accept  = in_valid && (state == ACCUM);
  assign last    = (cnt == SH'(COUNT - 1));
  assign done    = (state == HOLD) && out_ready;
  assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(sum_in);
  assign ovf_add = sum_ext[ACC_W];
  assign ovf_nx  = sticky | ovf_add;
  assign acc_nx  = ovf_add ? '1 : sum_ext[ACC_W-1:0];
  assign shifted = acc_nx >> SH;
  // average is clamped because wide accumulators can exceed 5 bits
  assign avg_nx  = (shifted > ACC_W'(31)) ? 5'd31 : shifted[4:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sticky  <= 1'b0;
      acc_out <= '0;
      avg_out <= '0;
      ovf     <= 1'b0;
    end else if (done) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (accept) begin
      acc    <= acc_nx;
      sticky <= ovf_nx;
      if (last) begin
        acc_out <= acc_nx;
        avg_out <= avg_nx;
        ovf     <= ovf_nx;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: default instance plus a 6-bit
// accumulator instance sharing the same stimulus.
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sum_in;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready;
  logic [7:0] acc_out;
  logic [4:0] avg_out;
  logic       ovf;
  logic       out_valid;

  logic       s_in_ready;
  logic [5:0] s_acc_out;
  logic [4:0] s_avg_out;
  logic       s_ovf;
  logic       s_out_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_accum u_dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .avg_out   (avg_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  sum_accum #(.COUNT(4), .ACC_W(6)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .acc_out   (s_acc_out),
    .avg_out   (s_avg_out),
    .ovf       (s_ovf),
    .out_valid (s_out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [4:0] d,
                      input bit gap);
    logic [4:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      sum_in   = v[i];
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      sum_in   = 5'd30;
      if (i < 3) begin
        check("early_valid", 32'(out_valid), 0);
        if (gap) begin
          step();
          check("gap_valid", 32'(out_valid), 0);
        end
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 0);
    check("post_hs_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    sum_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_acc", 32'(acc_out), 0);
    check("rst_avg", 32'(avg_out), 0);
    check("rst_ovf", 32'(ovf), 0);

    feed(8, 11, 8, 11, 1'b0);
    check("basic_valid", 32'(out_valid), 1);
    check("basic_ready", 32'(in_ready), 0);
    check("basic_acc", 32'(acc_out), 38);
    check("basic_avg", 32'(avg_out), 9);
    check("basic_ovf", 32'(ovf), 0);
    consume();
    check("keep_acc", 32'(acc_out), 38);

    feed(8, 11, 8, 11, 1'b1);
    check("gap_valid_end", 32'(out_valid), 1);
    check("gap_acc", 32'(acc_out), 38);
    check("gap_avg", 32'(avg_out), 9);

    in_valid = 1'b1;
    sum_in   = 5'd30;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", 32'(in_ready), 0);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_acc", 32'(acc_out), 38);
      check("bp_avg", 32'(avg_out), 9);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_hs_valid", 32'(out_valid), 0);
    feed(1, 2, 3, 4, 1'b0);
    check("bp_next_acc", 32'(acc_out), 10);
    check("bp_next_avg", 32'(avg_out), 2);
    consume();

    rst = 1'b1;
    step();
    rst = 1'b0;
    feed(30, 30, 30, 30, 1'b0);
    check("sat_valid", 32'(s_out_valid), 1);
    check("sat_acc", 32'(s_acc_out), 63);
    check("sat_avg", 32'(s_avg_out), 15);
    check("sat_ovf", 32'(s_ovf), 1);
    check("wide_acc", 32'(acc_out), 120);
    check("wide_avg", 32'(avg_out), 30);
    check("wide_ovf", 32'(ovf), 0);
    consume();
    feed(1, 1, 1, 1, 1'b0);
    check("sat2_acc", 32'(s_acc_out), 4);
    check("sat2_avg", 32'(s_avg_out), 1);
    check("sat2_ovf", 32'(s_ovf), 0);
    consume();

    in_valid = 1'b1;
    sum_in   = 5'd8;
    step();
    sum_in = 5'd11;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_acc", 32'(acc_out), 0);
    feed(5, 5, 5, 5, 1'b0);
    check("mid_valid", 32'(out_valid), 1);
    check("mid_acc", 32'(acc_out), 20);
    check("mid_avg", 32'(avg_out), 5);

    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    check("hold_rst_valid", 32'(out_valid), 0);
    check("hold_rst_acc", 32'(acc_out), 0);
    check("hold_rst_ready", 32'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 The block SHALL have one clock `clk` and a synchronous, active-high reset `rst`; all state SHALL update only on the rising edge of `clk`.
REQ-002 Parameter `COUNT`, default 4: number of sums per frame; it SHALL be a power of two, 2..64.
REQ-003 Parameter `ACC_W`, default 8: accumulator width; it SHALL be at least 6.
REQ-004 `clk`  in  1  system clock.
REQ-005 `rst`  in  1  synchronous active-high reset.
REQ-006 `sum_in`  in  5  unsigned sum from the upstream 4-bit adder stage (range 0..30).
REQ-007 `in_valid`  in  1  `sum_in` is valid this cycle.
REQ-008 `in_ready`  out  1  block accepts `sum_in` this cycle.
REQ-009 `acc_out`  out  ACC_W  frame total, unsigned, saturating.
REQ-010 `avg_out`  out  5  frame average: floor(`acc_out`/`COUNT`), clamped to 31.
REQ-011 `ovf`  out  1  the frame total saturated.
REQ-012 `out_valid`  out  1  frame result is valid.
REQ-013 `out_ready`  in  1  downstream consumes the result.

Function
REQ-014 FSM states SHALL be ACCUM and HOLD; reset SHALL enter ACCUM.
REQ-015 In ACCUM: `in_ready`=1 and `out_valid`=0; in HOLD: `in_ready`=0 and `out_valid`=1.
REQ-016 A sum SHALL be accepted only on a cycle where `in_valid` && `in_ready` is high.
- `sum_in` on any other cycle SHALL be ignored.
- Gaps in `in_valid` SHALL NOT affect the result.
REQ-017 Each accepted sum SHALL add, zero-extended to ACC_W, to the internal accumulator and increment the sample counter `cnt`.
REQ-018 Saturation SHALL work as follows:
- If an addition would exceed 2^ACC_W-1, the accumulator SHALL hold 2^ACC_W-1.
- A sticky overflow bit SHALL set and stay set until the frame is consumed.
REQ-019 Frame completion SHALL work as follows:
- On the accept where `cnt` == `COUNT`-1, the FSM SHALL go to HOLD on the next edge.
- On that same edge, `acc_out`, `avg_out` and `ovf` SHALL register the final values, including that last sum.
- Latency from the last accept to `out_valid`=1 SHALL be exactly 1 cycle.
REQ-020 In HOLD, `acc_out`, `avg_out` and `ovf` SHALL remain stable until a `out_valid` && `out_ready` handshake.
REQ-021 On the handshake edge, the block SHALL:
- clear the accumulator, `cnt` and sticky overflow;
- return to ACCUM, with `in_ready`=1 on the next cycle.
- No input is accepted on the handshake cycle itself.
REQ-022 `avg_out` SHALL equal `acc_out` >> log2(`COUNT`), saturated to 31 if wider.
REQ-023 `acc_out`, `avg_out` and `ovf` SHALL keep their last frame values while in ACCUM, and SHALL be 0 before the first frame.
REQ-024 `cnt` SHALL wrap only through REQ-021 and SHALL never exceed `COUNT`-1.

Reset
REQ-025 With `rst`=1 at an edge, the block SHALL:
- go to ACCUM and clear `cnt`, the accumulator and sticky overflow;
- set `acc_out`=0, `avg_out`=0, `ovf`=0, `out_valid`=0, and `in_ready`=1 after that edge.
REQ-026 Reset SHALL take priority over any simultaneous handshake, including a reset mid-frame or in HOLD; a partial frame SHALL be discarded.

Verification
REQ-027 Basic frame, default params: accept sums 8,11,8,11 on consecutive cycles -> one cycle later `out_valid`=1, `acc_out`=38, `avg_out`=9, `ovf`=0.
REQ-028 Gapped input: `in_valid` toggles 1,0,1,0,... with sums 8,11,8,11 -> same result as REQ-027; `out_valid` rises only after the 4th accepted sum.
REQ-029 Backpressure: hold `out_ready`=0 for 5 cycles in HOLD and drive `in_valid`=1 with sum=30 -> `in_ready`=0, outputs stable at 38/9; after the handshake the next frame starts from 0.
REQ-030 Saturation, ACC_W=6: accept 30,30,30,30 -> `acc_out`=63, `avg_out`=15, `ovf`=1; the next frame of 1,1,1,1 gives `acc_out`=4, `ovf`=0.
REQ-031 Reset mid-frame: accept 8,11, assert `rst` for 1 cycle, then accept 5,5,5,5 -> `acc_out`=20, `avg_out`=5; no `out_valid` pulse appears before the new 4th sum.
REQ-032 Reset in HOLD while `out_ready`=1 -> after the edge `out_valid`=0 and `acc_out`=0.
